// File: rtl/i2s_ctrl_pkg.sv
// Shared types and default widths for the I2S TX scheduler slice.
// Optional build macro used by this slice: I2S_TX_FIXED_PRIO_EN (fixed-priority arbitration).
package i2s_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } tx_state_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_FIFO_AW = 2;
  localparam int DEF_DW      = 32;
  localparam int DEF_UCNT_W  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Requester arbiter: combinational one-hot grant gated by i_en; pointer advances past the winner on i_advance.
// Macro I2S_TX_FIXED_PRIO_EN selects fixed priority (lowest index wins, no pointer state).
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  input  logic         i_advance,
  output logic [N-1:0] o_grant
);

`ifdef I2S_TX_FIXED_PRIO_EN
  logic unused_ok;
  logic found;

  assign unused_ok = ^{i_clk, i_rst_n, i_advance};

  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && i_req[i]) begin
        o_grant[i] = 1'b1;
        found      = 1'b1;
      end
    end
    if (!i_en) o_grant = '0;
  end
`else
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          found;
  int            idx;

  // Search starts at the pointer and wraps, so the last winner is tried last.
  always_comb begin
    o_grant = '0;
    gidx    = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        gidx         = PW'(idx);
        found        = 1'b1;
      end
    end
    if (!i_en) o_grant = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (i_advance && |o_grant) begin
      ptr <= (int'(gidx) == N - 1) ? '0 : gidx + PW'(1);
    end
  end
`endif

endmodule

// File: rtl/i2s_tx_scheduler.sv
// Stereo TX scheduler: arbitrated paired L/R FIFO writes, prefill/run/drain enable sequencing, underrun counting.
// Grants are combinational and held off while the FIFO pair is full or the FSM is IDLE/DRAIN; macro I2S_TX_FIXED_PRIO_EN.
module i2s_tx_scheduler
  import i2s_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int FIFO_AW = DEF_FIFO_AW,
  parameter int DW      = DEF_DW,
  parameter int UCNT_W  = DEF_UCNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [FIFO_AW:0]      i_prefill,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ*DW-1:0] i_req_left,
  input  logic [NUM_REQ*DW-1:0] i_req_right,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic                  o_fifo_wr,
  output logic [DW-1:0]         o_fifo_wdata_l,
  output logic [DW-1:0]         o_fifo_wdata_r,
  input  logic                  i_fifol_full,
  input  logic                  i_fifor_full,
  input  logic                  i_data_rqst,
  output logic                  o_i2s_enable,
  output logic [FIFO_AW:0]      o_level,
  output logic [UCNT_W-1:0]     o_underrun_cnt,
  output logic                  o_underrun_irq,
  input  logic                  i_underrun_clr,
  output logic [1:0]            o_state
);

  localparam int              LW    = FIFO_AW + 1;
  localparam logic [LW-1:0]   DEPTH = LW'(1) << FIFO_AW;

  tx_state_e          state, state_nxt;
  logic [LW-1:0]      level, level_nxt, pf;
  logic [NUM_REQ-1:0] grant;
  logic               can_wr, wr, pop, underrun;
  logic [UCNT_W-1:0]  ucnt;
  logic               irq, i2s_en;

  always_comb begin
    pf = i_prefill;
    if (i_prefill == '0)        pf = LW'(1);
    else if (i_prefill > DEPTH) pf = DEPTH;
  end

  assign can_wr = ((state == FILL) || (state == RUN)) && (level < DEPTH) &&
                  !i_fifol_full && !i_fifor_full;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req_valid),
    .i_en      (can_wr),
    .i_advance (wr),
    .o_grant   (grant)
  );

  assign wr = |grant;

  always_comb begin
    o_fifo_wdata_l = '0;
    o_fifo_wdata_r = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_fifo_wdata_l = o_fifo_wdata_l | (i_req_left[k*DW +: DW]  & {DW{grant[k]}});
      o_fifo_wdata_r = o_fifo_wdata_r | (i_req_right[k*DW +: DW] & {DW{grant[k]}});
    end
  end

  // A pop against an empty FIFO pair consumes nothing; it only counts as an underrun.
  assign pop      = i_data_rqst && (level != '0);
  assign underrun = i_data_rqst && (level == '0);

  always_comb begin
    level_nxt = level;
    case ({wr, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_enable) state_nxt = FILL;
      // Post-update level, so the write that completes prefill also starts the master.
      FILL:  if (!i_enable) state_nxt = IDLE;
             else if (level_nxt >= pf) state_nxt = RUN;
      RUN:   if (!i_enable) state_nxt = DRAIN;
      DRAIN: if (i_enable) state_nxt = RUN;
             else if (level == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      level  <= '0;
      i2s_en <= 1'b0;
      irq    <= 1'b0;
      ucnt   <= '0;
    end else begin
      state  <= state_nxt;
      level  <= level_nxt;
      i2s_en <= (state_nxt == RUN) || (state_nxt == DRAIN);
      irq    <= underrun;
      if (underrun) begin
        if (i_underrun_clr) ucnt <= UCNT_W'(1);
        else if (ucnt != '1) ucnt <= ucnt + UCNT_W'(1);
      end else if (i_underrun_clr) begin
        ucnt <= '0;
      end
    end
  end

  assign o_req_ready    = grant;
  assign o_fifo_wr      = wr;
  assign o_level        = level;
  assign o_i2s_enable   = i2s_en;
  assign o_underrun_cnt = ucnt;
  assign o_underrun_irq = irq;
  assign o_state        = state;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Bench for i2s_tx_scheduler: directed phases plus random traffic against a cycle-level reference model.
module tb_i2s_tx_scheduler;
  import i2s_ctrl_pkg::*;

  localparam int NR    = 2;
  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int UW    = 4;
  localparam int DEPTH = 4;
  localparam int MAXC  = 15;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [AW:0]    prefill;
  logic [NR-1:0]  vld;
  logic [NR*DW-1:0] left, right;
  logic [NR-1:0]  ready;
  logic           fifo_wr;
  logic [DW-1:0]  wdl, wdr;
  logic           fl, fr, rqst, clr;
  logic           i2s_en;
  logic [AW:0]    level;
  logic [UW-1:0]  ucnt;
  logic           irq;
  logic [1:0]     state;

  int checks = 0;
  int errors = 0;

  tx_state_e m_state;
  int        m_lvl, m_ptr, m_cnt, nwr;
  logic      m_irq, m_en;
  int        cntr [NR];

  always #5 clk = ~clk;

  i2s_tx_scheduler #(.NUM_REQ(NR), .FIFO_AW(AW), .DW(DW), .UCNT_W(UW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (en),
    .i_prefill      (prefill),
    .i_req_valid    (vld),
    .i_req_left     (left),
    .i_req_right    (right),
    .o_req_ready    (ready),
    .o_fifo_wr      (fifo_wr),
    .o_fifo_wdata_l (wdl),
    .o_fifo_wdata_r (wdr),
    .i_fifol_full   (fl),
    .i_fifor_full   (fr),
    .i_data_rqst    (rqst),
    .o_i2s_enable   (i2s_en),
    .o_level        (level),
    .o_underrun_cnt (ucnt),
    .o_underrun_irq (irq),
    .i_underrun_clr (clr),
    .o_state        (state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] smp_l(input int k, input int n);
    return 32'(32'h1000 + 32'h2000 * k + n);
  endfunction

  task automatic drive_data();
    for (int k = 0; k < NR; k++) begin
      left[k*DW +: DW]  = smp_l(k, cntr[k]);
      right[k*DW +: DW] = smp_l(k, cntr[k]) + 32'h1000;
    end
  endtask

  task automatic model_reset();
    m_state = IDLE; m_lvl = 0; m_ptr = 0; m_cnt = 0; m_irq = 1'b0; m_en = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, return at posedge+1.
  task automatic cycle();
    int g, pre, pf;
    logic can, ur;
    logic [NR-1:0] eg;
    @(negedge clk);
    chk("state", state, m_state);
    chk("level", level, m_lvl);
    chk("i2s_en", i2s_en, m_en);
    chk("ucnt", ucnt, m_cnt);
    chk("irq", irq, m_irq);
    can = ((m_state == FILL) || (m_state == RUN)) && (m_lvl < DEPTH) && !fl && !fr;
    g = -1;
    if (can) begin
      for (int i = 0; i < NR; i++) begin
        int c;
        c = (m_ptr + i) % NR;
        if (g < 0 && vld[c]) g = c;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("ready", ready, eg);
    chk("fifo_wr", fifo_wr, g >= 0);
    if (g >= 0) begin
      chk("wdata_l", wdl, smp_l(g, cntr[g]));
      chk("wdata_r", wdr, smp_l(g, cntr[g]) + 32'h1000);
    end
    pre = m_lvl;
    ur  = rqst && (pre == 0);
    if (rqst && pre > 0) m_lvl--;
    if (g >= 0) begin
      m_lvl++;
      cntr[g]++;
      nwr++;
`ifdef I2S_TX_FIXED_PRIO_EN
      m_ptr = 0;
`else
      m_ptr = (g + 1) % NR;
`endif
    end
    m_irq = ur;
    if (ur) m_cnt = clr ? 1 : ((m_cnt == MAXC) ? MAXC : m_cnt + 1);
    else if (clr) m_cnt = 0;
    pf = (prefill == 0) ? 1 : ((int'(prefill) > DEPTH) ? DEPTH : int'(prefill));
    case (m_state)
      IDLE:  if (en) m_state = FILL;
      FILL:  if (!en) m_state = IDLE; else if (m_lvl >= pf) m_state = RUN;
      RUN:   if (!en) m_state = DRAIN;
      DRAIN: if (en) m_state = RUN; else if (pre == 0) m_state = IDLE;
      default: m_state = IDLE;
    endcase
    m_en = (m_state == RUN) || (m_state == DRAIN);
    @(posedge clk);
    #1;
    drive_data();
  endtask

  initial begin
    int n0, lim;
    rst_n = 1'b1; en = 1'b0; prefill = '0; vld = '0; fl = 1'b0; fr = 1'b0;
    rqst = 1'b0; clr = 1'b0; nwr = 0;
    for (int k = 0; k < NR; k++) cntr[k] = 0;
    drive_data();
    #2 rst_n = 1'b0;
    vld = 2'b11;
    #1;
    chk("rst_state", state, 0);
    chk("rst_ready", ready, 0);
    chk("rst_wr", fifo_wr, 0);
    chk("rst_en", i2s_en, 0);
    chk("rst_level", level, 0);
    chk("rst_ucnt", ucnt, 0);
    chk("rst_irq", irq, 0);
    vld = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Prefill of 3 from requester 0
    prefill = 3; en = 1'b1; vld = 2'b01; n0 = nwr;
    for (lim = 0; lim < 20 && state != RUN; lim++) cycle();
    chk("pf_state", state, RUN);
    chk("pf_writes", nwr - n0, 3);
    chk("pf_en", i2s_en, 1);
    chk("pf_level", level, 3);

    // Round-robin with periodic pops; full flags toggled in the second half
    vld = 2'b11;
    for (int i = 0; i < 24; i++) begin
      rqst = (i % 4 == 0);
      fl   = (i >= 12) && ($urandom_range(0, 2) == 0);
      fr   = (i >= 12) && ($urandom_range(0, 2) == 0);
      cycle();
    end
    rqst = 1'b0; fl = 1'b0; fr = 1'b0; vld = '0;

    // Underrun: drain to level 1, then two pops 10 cycles apart
    for (lim = 0; lim < 8 && level > 1; lim++) begin rqst = 1'b1; cycle(); end
    rqst = 1'b0;
    chk("ur_level1", level, 1);
    rqst = 1'b1; cycle(); rqst = 1'b0;
    chk("ur_level0", level, 0);
    repeat (9) cycle();
    rqst = 1'b1; cycle(); rqst = 1'b0;
    chk("ur_cnt1", ucnt, 1);
    chk("ur_irq", irq, 1);
    cycle();
    chk("ur_irq_off", irq, 0);
    rqst = 1'b1; clr = 1'b1; cycle(); rqst = 1'b0; clr = 1'b0;
    chk("ur_clr_inc", ucnt, 1);
    rqst = 1'b1; repeat (20) cycle(); rqst = 1'b0;
    chk("ur_sat", ucnt, MAXC);
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("ur_clr", ucnt, 0);

    // Drain with a mid-drain re-enable
    vld = 2'b11;
    for (lim = 0; lim < 12 && level != 4; lim++) cycle();
    chk("dr_full", level, 4);
    en = 1'b0; cycle();
    chk("dr_state", state, DRAIN);
    rqst = 1'b1; repeat (2) cycle(); rqst = 1'b0;
    vld = '0; en = 1'b1; cycle();
    chk("dr_rerun", state, RUN);
    chk("dr_rerun_en", i2s_en, 1);
    en = 1'b0; vld = 2'b11; cycle();
    for (lim = 0; lim < 8 && level > 0; lim++) begin rqst = 1'b1; cycle(); end
    rqst = 1'b0;
    chk("dr_last_state", state, DRAIN);
    chk("dr_last_en", i2s_en, 1);
    cycle();
    chk("dr_idle", state, IDLE);
    chk("dr_en_off", i2s_en, 0);
    vld = '0;

    // FILL aborted by disable keeps its frames for the next fill
    prefill = 4; en = 1'b1; vld = 2'b01;
    for (lim = 0; lim < 10 && level != 2; lim++) cycle();
    vld = '0; en = 1'b0; cycle();
    chk("ret_idle", state, IDLE);
    chk("ret_level", level, 2);
    prefill = 3; en = 1'b1; vld = 2'b01; n0 = nwr;
    for (lim = 0; lim < 10 && state != RUN; lim++) cycle();
    chk("ret_run", state, RUN);
    chk("ret_writes", nwr - n0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) prefill = 3'($urandom_range(0, 7));
      vld  = 2'($urandom_range(0, 3));
      fl   = ($urandom_range(0, 7) == 0);
      fr   = ($urandom_range(0, 7) == 0);
      rqst = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 19) == 0);
      cycle();
    end
    fl = 1'b0; fr = 1'b0; rqst = 1'b0; clr = 1'b0;

    // Asynchronous reset with a write in flight
    en = 1'b1; prefill = 1; vld = 2'b01;
    for (lim = 0; lim < 20 && !(state == RUN && level < 4); lim++) begin
      rqst = (level == 4); cycle();
    end
    rqst = 1'b0;
    #2;
    chk("rr_wr_inflight", fifo_wr, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_ready", ready, 0);
    chk("arst_wr", fifo_wr, 0);
    chk("arst_en", i2s_en, 0);
    chk("arst_level", level, 0);
    chk("arst_ucnt", ucnt, 0);
    chk("arst_irq", irq, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    vld = 2'b11;
    repeat (12) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
